prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that sits directly upstream of the single-cycle MIPS core's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses (the PC advances by 1 per instruction). It holds the core in reset until the whole program is written, then releases it.

## Interface
- ADDR_WIDTH, 8, instruction-memory depth in words is 2**ADDR_WIDTH; sets the overflow limit

- clk  input  1  system clock; all logic updates on the rising edge
- rst  input  1  reset, synchronous, active-high
- rx_valid  input  1  rx_data holds a byte
- rx_data  input  8  stream byte
- rx_ready  output  1  loader can accept a byte; a transfer occurs on a cycle where rx_valid && rx_ready
- reload  input  1  single-cycle request to load a new program; honoured only in DONE
- im_we  output  1  instruction-memory write strobe
- im_addr  output  32  word address, zero-extended word index
- im_wdata  output  32  assembled instruction word
- cpu_rst  output  1  reset to the MIPS core (the core's rst)
- done  output  1  program loaded and core released
- overflow  output  1  sticky; the program had more words than the memory holds
- words_loaded  output  16  number of words written so far

## Operation
- Stream format:
  - Two bytes give the word count N, high byte first.
  - Then N×4 bytes, each word big-endian (the first byte goes to bits [31:24]).
- States: CNT_HI → CNT_LO → WORD → WRITE → (WORD | DONE). DONE → CNT_HI on reload.
- CNT_HI:
  - rx_ready=1.
  - On transfer, latch count[15:8] and go to CNT_LO.
- CNT_LO:
  - rx_ready=1.
  - On transfer, latch count[7:0].
  - If the full count is 0, go to DONE. Otherwise clear the byte index and go to WORD.
- WORD:
  - rx_ready=1.
  - On each transfer, shift the byte into the assembly register at position 3−byte_idx.
  - After the 4th byte (byte_idx=3), go to WRITE.
- WRITE:
  - rx_ready=0, im_we=1 for exactly this cycle.
  - im_addr = word index; im_wdata = assembled word.
  - Then increment the word index and words_loaded.
  - If the new index equals N, go to DONE; otherwise go to WORD with byte_idx=0.
- Overflow:
  - If word index ≥ 2**ADDR_WIDTH in WRITE, im_we is forced to 0 and overflow is set (sticky until rst or reload).
  - The stream is still fully consumed and words_loaded still counts.
- DONE:
  - rx_ready=0, done=1, cpu_rst=0.
  - reload=1 clears the word index, words_loaded and overflow, and goes to CNT_HI with cpu_rst=1 on the next cycle.
- cpu_rst = 1 in every state except DONE. Registered, so it changes on the clock edge that enters or leaves DONE.
- No stalls are needed beyond rx_ready. rx_valid without rx_ready is ignored; no byte is lost as long as the producer holds data until ready.

## Timing
- Reset values: state=CNT_HI, rx_ready=1, im_we=0, im_addr=0, im_wdata=0, cpu_rst=1, done=0, overflow=0, words_loaded=0.
- rst wins over every other input, including reload and rx_valid, in the same cycle.
- Reset mid-load returns to CNT_HI. Instruction-memory contents already written are not cleared.
- Throughput is 5 cycles per word with rx_valid held high: 4 accept cycles + 1 WRITE cycle.
- Latency:
  - im_we rises the cycle after the 4th byte is accepted.
  - done/cpu_rst change the cycle after the last WRITE.
  - With N=0, done rises the cycle after the count low byte is accepted.
- A reload pulse outside DONE has no effect.
- Word count wraps nowhere: N is 16 bits, and the word index is 16 bits compared against N only.

## Test plan
- Stream 00 02 | 20 08 00 05 | AC 08 00 00 with rx_valid held high:
  - im_we pulses at addr 0 with data 0x20080005, then at addr 1 with data 0xAC080000.
  - done=1 and cpu_rst=0 are seen 11 cycles after the first accept.
  - words_loaded=2.
- Stream 00 00: no im_we; done rises the cycle after the second byte.
- Backpressure: toggle rx_valid randomly on a 1-word program 00 01 | 12 34 56 78. Result is a single write of 0x12345678 at addr 0, and rx_ready=0 during the WRITE cycle.
- ADDR_WIDTH=2, N=5:
  - Writes occur at addr 0–3 only; the 5th WRITE has im_we=0.
  - overflow=1, words_loaded=5, done=1.
- Assert rst after 2 bytes of word 1 (N=3):
  - Outputs return to reset values the next cycle.
  - A fresh stream 00 01 | DE AD BE EF writes 0xDEADBEEF at addr 0.
- In DONE, pulse reload together with rst: result is the reset state. Then pulse reload alone: cpu_rst=1, done=0, overflow=0, rx_ready=1 on the next cycle.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time loader: assembles a big-endian byte stream into 32-bit words,
// writes them to instruction memory and holds the core in reset until loaded.
module prog_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        reload,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        overflow,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        CNT_HI,
        CNT_LO,
        WORD,
        WRITE,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] asm_q, asm_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [15:0] words_loaded_q, words_loaded_d;
    logic        overflow_q, overflow_d;

    logic        xfer;
    logic        ovf_hit;
    logic [15:0] word_idx_inc;

    // Any index bit at or above ADDR_WIDTH means the word lies beyond memory.
    assign ovf_hit      = (word_idx_q >> ADDR_WIDTH) != 16'd0;
    assign word_idx_inc = word_idx_q + 16'd1;

    assign rx_ready     = (state_q == CNT_HI) || (state_q == CNT_LO) || (state_q == WORD);
    assign xfer         = rx_valid && rx_ready;
    assign im_we        = (state_q == WRITE) && !ovf_hit;
    assign im_addr      = {16'd0, word_idx_q};
    assign im_wdata     = asm_q;
    assign done         = (state_q == DONE);
    assign cpu_rst      = (state_q != DONE);
    assign overflow     = overflow_q;
    assign words_loaded = words_loaded_q;

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        byte_idx_d     = byte_idx_q;
        asm_d          = asm_q;
        word_idx_d     = word_idx_q;
        words_loaded_d = words_loaded_q;
        overflow_d     = overflow_q;

        case (state_q)
            CNT_HI: begin
                if (xfer) begin
                    count_d[15:8] = rx_data;
                    state_d       = CNT_LO;
                end
            end
            CNT_LO: begin
                if (xfer) begin
                    count_d[7:0] = rx_data;
                    if ({count_q[15:8], rx_data} == 16'd0) begin
                        state_d = DONE;
                    end else begin
                        byte_idx_d = 2'd0;
                        state_d    = WORD;
                    end
                end
            end
            WORD: begin
                if (xfer) begin
                    case (byte_idx_q)
                        2'd0:    asm_d[31:24] = rx_data;
                        2'd1:    asm_d[23:16] = rx_data;
                        2'd2:    asm_d[15:8]  = rx_data;
                        default: asm_d[7:0]   = rx_data;
                    endcase
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                word_idx_d     = word_idx_inc;
                words_loaded_d = words_loaded_q + 16'd1;
                if (ovf_hit) begin
                    overflow_d = 1'b1;
                end
                if (word_idx_inc == count_q) begin
                    state_d = DONE;
                end else begin
                    byte_idx_d = 2'd0;
                    state_d    = WORD;
                end
            end
            DONE: begin
                if (reload) begin
                    word_idx_d     = 16'd0;
                    words_loaded_d = 16'd0;
                    overflow_d     = 1'b0;
                    state_d        = CNT_HI;
                end
            end
            default: state_d = CNT_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= CNT_HI;
            count_q        <= 16'd0;
            byte_idx_q     <= 2'd0;
            asm_q          <= 32'd0;
            word_idx_q     <= 16'd0;
            words_loaded_q <= 16'd0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            byte_idx_q     <= byte_idx_d;
            asm_q          <= asm_d;
            word_idx_q     <= word_idx_d;
            words_loaded_q <= words_loaded_d;
            overflow_q     <= overflow_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a full-size and a 4-word instance share one stream;
// expectations come from decoding the stream bytes directly.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst, rx_valid, reload;
    logic [7:0]  rx_data;

    logic        rx_ready, im_we, cpu_rst, done, overflow;
    logic [31:0] im_addr, im_wdata;
    logic [15:0] words_loaded;
    logic        rx_ready_s, im_we_s, cpu_rst_s, done_s, overflow_s;
    logic [31:0] im_addr_s, im_wdata_s;
    logic [15:0] words_loaded_s;

    localparam int DEPTH_BIG   = 256;
    localparam int DEPTH_SMALL = 4;
    localparam logic [84:0] RST_VEC = {1'b1, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 16'd0};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  stim[$];
    logic [31:0] wa[$], wd[$], sa[$], sd[$];
    int          acc_edges[$];
    int          first_we = -1;
    int          done_rise = -1;
    logic        done_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prog_loader #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .reload(reload), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .cpu_rst(cpu_rst), .done(done), .overflow(overflow),
        .words_loaded(words_loaded)
    );

    prog_loader #(.ADDR_WIDTH(2)) dut_s (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready_s), .reload(reload), .im_we(im_we_s), .im_addr(im_addr_s),
        .im_wdata(im_wdata_s), .cpu_rst(cpu_rst_s), .done(done_s), .overflow(overflow_s),
        .words_loaded(words_loaded_s)
    );

    // Write capture; also confirms the loader refuses bytes while writing.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            if (wa.size() == 0) first_we = cyc;
            wa.push_back(im_addr);
            wd.push_back(im_wdata);
            checks++;
            if (rx_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_write: rx_ready=%b required 0", rx_ready);
            end
        end
        if (im_we_s === 1'b1) begin
            sa.push_back(im_addr_s);
            sd.push_back(im_wdata_s);
        end
        if (done === 1'b1 && done_prev !== 1'b1) done_rise = cyc;
        done_prev = done;
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        reload   = gaps && ($urandom_range(0, 5) == 0);
        while (rx_ready !== 1'b1) begin
            @(negedge clk);
            reload = 1'b0;
            waited++;
            if (waited > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: byte %h not accepted after %0d cycles, required acceptance", b, waited);
                rx_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        acc_edges.push_back(cyc);
        @(negedge clk);
        rx_valid = 1'b0;
        reload   = 1'b0;
    endtask

    task automatic run_program(input bit gaps, input string name);
        int n, nb, ns, tmo, exp_rise;
        logic [31:0] w;
        if (done === 1'b1) begin
            reload = 1'b1;
            @(negedge clk);
            reload = 1'b0;
        end
        wa.delete(); wd.delete(); sa.delete(); sd.delete(); acc_edges.delete();
        first_we  = -1;
        done_rise = -1;
        foreach (stim[i]) send_byte(stim[i], gaps);
        tmo = 0;
        while (!(done === 1'b1 && done_s === 1'b1) && tmo < 20) begin
            @(negedge clk);
            tmo++;
        end
        @(negedge clk);

        n  = int'({stim[0], stim[1]});
        nb = (n > DEPTH_BIG) ? DEPTH_BIG : n;
        ns = (n > DEPTH_SMALL) ? DEPTH_SMALL : n;

        checks++;
        if (done !== 1'b1 || done_s !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: done=%b done_s=%b required 1 1", name, done, done_s);
        end
        checks++;
        if (wa.size() != nb) begin
            errors++;
            $display("FAIL %s_wr_count: got %0d writes required %0d", name, wa.size(), nb);
        end
        for (int i = 0; i < nb && i < wa.size(); i++) begin
            w = {stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]};
            checks++;
            if (wa[i] !== 32'(i) || wd[i] !== w) begin
                errors++;
                $display("FAIL %s_write%0d: got addr %h data %h required addr %h data %h", name, i, wa[i], wd[i], 32'(i), w);
            end
        end
        checks++;
        if (sa.size() != ns) begin
            errors++;
            $display("FAIL %s_small_wr_count: got %0d writes required %0d", name, sa.size(), ns);
        end
        for (int i = 0; i < ns && i < sa.size(); i++) begin
            w = {stim[2+4*i], stim[3+4*i], stim[4+4*i], stim[5+4*i]};
            checks++;
            if (sa[i] !== 32'(i) || sd[i] !== w) begin
                errors++;
                $display("FAIL %s_small_write%0d: got addr %h data %h required addr %h data %h", name, i, sa[i], sd[i], 32'(i), w);
            end
        end
        checks++;
        if (words_loaded !== 16'(n) || words_loaded_s !== 16'(n)) begin
            errors++;
            $display("FAIL %s_words_loaded: got %0d/%0d required %0d", name, words_loaded, words_loaded_s, n);
        end
        checks++;
        if (overflow !== (n > DEPTH_BIG) || overflow_s !== (n > DEPTH_SMALL)) begin
            errors++;
            $display("FAIL %s_overflow: got %b/%b required %b/%b", name, overflow, overflow_s, n > DEPTH_BIG, n > DEPTH_SMALL);
        end
        checks++;
        if (cpu_rst !== 1'b0 || rx_ready !== 1'b0 || cpu_rst_s !== 1'b0) begin
            errors++;
            $display("FAIL %s_released: cpu_rst=%b rx_ready=%b required 0 0", name, cpu_rst, rx_ready);
        end
        exp_rise = acc_edges[acc_edges.size()-1] + ((n > 0) ? 1 : 0);
        checks++;
        if (done_rise != exp_rise) begin
            errors++;
            $display("FAIL %s_done_latency: done rose at cycle %0d required %0d", name, done_rise, exp_rise);
        end
        if (n > 0) begin
            checks++;
            if (first_we != acc_edges[5]) begin
                errors++;
                $display("FAIL %s_we_latency: im_we rose at cycle %0d required %0d", name, first_we, acc_edges[5]);
            end
        end
        $display("program %s: N=%0d writes=%0d small_writes=%0d overflow_s=%b", name, n, wa.size(), sa.size(), overflow_s);
    endtask

    task automatic push_word(input logic [31:0] w);
        stim.push_back(w[31:24]);
        stim.push_back(w[23:16]);
        stim.push_back(w[15:8]);
        stim.push_back(w[7:0]);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF; reload = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rx_ready, im_we, im_addr, im_wdata, cpu_rst, done, overflow, words_loaded} !== RST_VEC ||
            {rx_ready_s, im_we_s, im_addr_s, im_wdata_s, cpu_rst_s, done_s, overflow_s, words_loaded_s} !== RST_VEC) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", {rx_ready, im_we, im_addr, im_wdata, cpu_rst, done, overflow, words_loaded}, RST_VEC);
        end
        rst = 1'b0; rx_valid = 1'b0; reload = 1'b0;
        $display("reset applied");
    endtask

    task automatic test_basic();
        stim.delete();
        stim.push_back(8'h00); stim.push_back(8'h02);
        push_word(32'h20080005);
        push_word(32'hAC080000);
        run_program(1'b0, "basic");
        checks++;
        if (done_rise != acc_edges[0] + 11) begin
            errors++;
            $display("FAIL basic_11_cycles: done rose at %0d required %0d", done_rise, acc_edges[0] + 11);
        end
    endtask

    task automatic test_zero_count();
        stim.delete();
        stim.push_back(8'h00); stim.push_back(8'h00);
        run_program(1'b0, "zero");
    endtask

    task automatic test_backpressure();
        stim.delete();
        stim.push_back(8'h00); stim.push_back(8'h01);
        push_word(32'h12345678);
        run_program(1'b1, "backpressure");
    endtask

    task automatic test_overflow();
        stim.delete();
        stim.push_back(8'h00); stim.push_back(8'h05);
        for (int i = 0; i < 5; i++) push_word($urandom);
        run_program(1'b0, "overflow");
    endtask

    task automatic test_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        checks++;
        if (cpu_rst !== 1'b1 || done !== 1'b0 || overflow_s !== 1'b0 || rx_ready !== 1'b1 || words_loaded_s !== 16'd0) begin
            errors++;
            $display("FAIL reload_alone: cpu_rst=%b done=%b overflow_s=%b rx_ready=%b wl=%0d required 1 0 0 1 0",
                     cpu_rst, done, overflow_s, rx_ready, words_loaded_s);
        end
        stim.delete();
        stim.push_back(8'h00); stim.push_back(8'h00);
        run_program(1'b0, "zero_before_rst_reload");
        reload = 1'b1; rst = 1'b1;
        @(negedge clk);
        reload = 1'b0; rst = 1'b0;
        checks++;
        if ({rx_ready, im_we, im_addr, im_wdata, cpu_rst, done, overflow, words_loaded} !== RST_VEC) begin
            errors++;
            $display("FAIL reload_with_rst: got %h required %h", {rx_ready, im_we, im_addr, im_wdata, cpu_rst, done, overflow, words_loaded}, RST_VEC);
        end
        $display("reload checks complete");
    endtask

    task automatic test_mid_reset();
        logic [7:0] partial[4] = '{8'h00, 8'h03, 8'h20, 8'h08};
        if (done === 1'b1) begin
            reload = 1'b1;
            @(negedge clk);
            reload = 1'b0;
        end
        for (int i = 0; i < 4; i++) send_byte(partial[i], 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({rx_ready, im_we, im_addr, im_wdata, cpu_rst, done, overflow, words_loaded} !== RST_VEC) begin
            errors++;
            $display("FAIL mid_reset: got %h required %h", {rx_ready, im_we, im_addr, im_wdata, cpu_rst, done, overflow, words_loaded}, RST_VEC);
        end
        stim.delete();
        stim.push_back(8'h00); stim.push_back(8'h01);
        push_word(32'hDEADBEEF);
        run_program(1'b0, "after_mid_reset");
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(0, 7);
            stim.delete();
            stim.push_back(8'h00); stim.push_back(8'(n));
            for (int i = 0; i < n; i++) push_word($urandom);
            run_program(1'($urandom_range(0, 1)), $sformatf("random%0d", t));
        end
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; reload = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_count();
        test_backpressure();
        test_overflow();
        test_reload();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
